axicb_scfifo_lvl: RTL

Single-clock FIFO with fill-level reporting, registered almost-full/almost-empty watermarks and optional sticky overflow/underflow error flags. Next generation of the crossbar's basic single-clock FIFO, used where upstream arbitration needs early back-pressure (afull) and downstream schedulers need occupancy (level) rather than only full/empty. Storage is the existing `axicb_scfifo_ram`; the optional pass-thru path is retained.

---
 rtl/axicb_scfifo_pkg.sv | 33 +++
 rtl/axicb_scfifo_ram.sv | 47 ++++
 rtl/axicb_scfifo_lvl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/axicb_scfifo_pkg.sv
// ============================================================================
// Module   : axicb_scfifo_pkg
// Purpose  : Shared width helper and parameter legality checks for the
//            level-reporting single-clock FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axicb_scfifo_pkg;

    localparam int c_min_addr_width = 1;
    localparam int c_max_addr_width = 12;

    // Pointers and level carry one extra bit so full and empty stay distinct.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit addr_width_ok(input int addr_width);
        return (addr_width >= c_min_addr_width) && (addr_width <= c_max_addr_width);
    endfunction

    function automatic bit afull_thresh_ok(input int addr_width, input int thresh);
        return (thresh >= 1) && (thresh <= (1 << addr_width));
    endfunction

    function automatic bit aempty_thresh_ok(input int addr_width, input int thresh);
        return (thresh >= 0) && (thresh <= ((1 << addr_width) - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/axicb_scfifo_ram.sv
// ============================================================================
// Module   : axicb_scfifo_ram
// Purpose  : FIFO storage array, one write port and one read port; read is
//            combinational (FFD_EN=0) or registered (FFD_EN=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axicb_scfifo_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FFD_EN     = 0
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [c_depth];

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    generate
        if (FFD_EN != 0) begin : g_rd_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge aclk) begin
                rd_data_q <= mem_q[rd_addr];
            end
            assign rd_data = rd_data_q;
        end else begin : g_rd_comb
            assign rd_data = mem_q[rd_addr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axicb_scfifo_lvl.sv
// ============================================================================
// Module   : axicb_scfifo_lvl
// Purpose  : Single-clock FWFT FIFO with fill level, registered afull/aempty
//            watermarks, optional pass-thru and optional sticky error flags.
//            Define AXICB_SCFIFO_ERR_EN to build the overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axicb_scfifo_lvl
    import axicb_scfifo_pkg::*;
#(
    parameter int PASS_THRU     = 0,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 2 ** ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    output logic                  full,
    output logic                  afull,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  pull,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int c_pw = ptr_width(ADDR_WIDTH);
    localparam logic [c_pw-1:0] c_depth      = c_pw'(2 ** ADDR_WIDTH);
    localparam logic [c_pw-1:0] c_afull_th   = c_pw'(AFULL_THRESH);
    localparam logic [c_pw-1:0] c_aempty_th  = c_pw'(AEMPTY_THRESH);

    generate
        if (!addr_width_ok(ADDR_WIDTH)) begin : g_bad_addr_width
            $error("axicb_scfifo_lvl: ADDR_WIDTH=%0d outside 1..12", ADDR_WIDTH);
        end
        if (!afull_thresh_ok(ADDR_WIDTH, AFULL_THRESH)) begin : g_bad_afull
            $error("axicb_scfifo_lvl: AFULL_THRESH=%0d illegal", AFULL_THRESH);
        end
        if (!aempty_thresh_ok(ADDR_WIDTH, AEMPTY_THRESH)) begin : g_bad_aempty
            $error("axicb_scfifo_lvl: AEMPTY_THRESH=%0d illegal", AEMPTY_THRESH);
        end
    endgenerate

    logic [c_pw-1:0]       wrptr_q, wrptr_d;
    logic [c_pw-1:0]       rdptr_q, rdptr_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic [c_pw-1:0]       w_level;
    logic [c_pw-1:0]       w_level_next;
    logic                  w_empty_flag;
    logic                  w_full_flag;
    logic                  w_pass_thru;
    logic                  w_clr;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_ram_rd;

    assign w_level      = wrptr_q - rdptr_q;
    assign w_empty_flag = (w_level == '0);
    assign w_full_flag  = (w_level == c_depth);
    assign w_clr        = srst | flush;

    generate
        if (PASS_THRU != 0) begin : g_pass_thru
            assign w_pass_thru = pull & w_empty_flag;
        end else begin : g_no_pass_thru
            assign w_pass_thru = 1'b0;
        end
    endgenerate

    // Full is judged on the current state, so a same-cycle pull never frees
    // room for a push arriving at a full FIFO.
    assign w_wr_acc = push & ~w_full_flag & ~w_pass_thru;
    assign w_rd_acc = pull & ~w_empty_flag;

    always_comb begin
        wrptr_d      = wrptr_q + c_pw'(w_wr_acc);
        rdptr_d      = rdptr_q + c_pw'(w_rd_acc);
        w_level_next = w_level + c_pw'(w_wr_acc) - c_pw'(w_rd_acc);
        if (w_clr) begin
            wrptr_d      = '0;
            rdptr_d      = '0;
            w_level_next = '0;
        end
        // Watermarks look at the next level so they line up with level output.
        afull_d  = (w_level_next >= c_afull_th);
        aempty_d = (w_level_next <= c_aempty_th);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wrptr_q  <= wrptr_d;
            rdptr_q  <= rdptr_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    axicb_scfifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FFD_EN     (0)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (w_wr_acc & ~w_clr),
        .wr_addr (wrptr_q[ADDR_WIDTH-1:0]),
        .wr_data (data_in),
        .rd_addr (rdptr_q[ADDR_WIDTH-1:0]),
        .rd_data (w_ram_rd)
    );

    assign level    = w_level;
    assign full     = w_full_flag;
    assign afull    = afull_q;
    assign aempty   = aempty_q;
    assign empty    = w_pass_thru ? ~push : w_empty_flag;
    assign data_out = w_pass_thru ? data_in : w_ram_rd;

`ifdef AXICB_SCFIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A pass-thru pull with a same-cycle push is a legal transfer, not an underflow.
    always_comb begin
        overflow_d  = overflow_q  | (~w_clr & push & w_full_flag);
        underflow_d = underflow_q | (~w_clr & pull & w_empty_flag & ~(w_pass_thru & push));
        if (srst) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

`default_nettype wire
